fetch_sequencer: RTL

- Multicycle control FSM for the Otter MCU.
- Sequences the PC register/next-PC mux pair: drives its PC_WRITE enable and PC_SOURCE select, and issues memory and register-file strobes for each instruction.
- Latches and services external interrupts (mtvec redirect) and MRET (mepc return).
- Sits between the decoder/branch-condition logic and the PC, memory and register-file datapath.

---
 rtl/fetch_sequencer_pkg.sv | 31 +++
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer_intr_pending.sv | 28 ++
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the Otter multicycle control path: state
// encodings, RV32I major opcodes and next-PC select codes.
package otter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] PCSEL_PLUS4  = 3'd0;
  localparam logic [2:0] PCSEL_JALR   = 3'd1;
  localparam logic [2:0] PCSEL_BRANCH = 3'd2;
  localparam logic [2:0] PCSEL_JAL    = 3'd3;
  localparam logic [2:0] PCSEL_MTVEC  = 3'd4;
  localparam logic [2:0] PCSEL_MEPC   = 3'd5;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder/datapath-facing signal bundle of the fetch sequencer.
// master = the sequencer itself, slave = the datapath around it.
interface fetch_sequencer_if;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic       BR_TAKEN;
  logic       INTR;
  logic       MIE;
  logic       PC_WRITE;
  logic [2:0] PC_SOURCE;
  logic       RST;
  logic       MEM_RDEN1;
  logic       MEM_RDEN2;
  logic       MEM_WE2;
  logic       REG_WRITE;
  logic       CSR_WE;
  logic       INT_TAKEN;
  logic       MRET_EXEC;

  modport master (
    input  OPCODE, FUNC3, BR_TAKEN, INTR, MIE,
    output PC_WRITE, PC_SOURCE, RST, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           REG_WRITE, CSR_WE, INT_TAKEN, MRET_EXEC
  );

  modport slave (
    output OPCODE, FUNC3, BR_TAKEN, INTR, MIE,
    input  PC_WRITE, PC_SOURCE, RST, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           REG_WRITE, CSR_WE, INT_TAKEN, MRET_EXEC
  );
endinterface

// File: rtl/fetch_sequencer_intr_pending.sv
// Interrupt-pending latch: remembers one request until it is serviced.
// Clear has priority over set, so a request arriving in the entry cycle
// is absorbed by that entry. Disabled (held at 0) while en is low.
module intr_pending (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic set,
  input  logic clr,
  output logic pending
);

  // Pending flag: gated by en, clear beats set, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (!en) begin
      pending <= 1'b0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (set) begin
      pending <= 1'b1;
    end else begin
      pending <= pending;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle control FSM for the Otter MCU: steps each instruction through
// FETCH/EXEC(/WB), drives PC load/select and memory/regfile strobes, and
// inserts an INTR cycle between instructions when an enabled request waits.
module fetch_sequencer
  import otter_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  fetch_sequencer_if.master bus
);

  localparam logic [2:0] S_INIT  = ST_INIT;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_EXEC  = ST_EXEC;
  localparam logic [2:0] S_WB    = ST_WB;
  localparam logic [2:0] S_INTR  = ST_INTR;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [3:0] init_cnt;
  logic       pending;
  logic       take_intr;
  logic       in_intr;

  assign in_intr   = (state == S_INTR);
  assign take_intr = pending & bus.MIE;

  intr_pending u_pending (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .en      (state != S_INIT),
    .set     (bus.INTR),
    .clr     (in_intr),
    .pending (pending)
  );

  // State register and INIT dwell counter; reset lands in INIT at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_INIT;
      init_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (state == S_INIT) begin
        init_cnt <= init_cnt + 4'd1;
      end else begin
        init_cnt <= 4'd0;
      end
    end
  end

  // Next-state logic; interrupts are only taken at instruction boundaries.
  always_comb begin
    next_state = S_INIT;
    case (state)
      S_INIT:  next_state = (init_cnt == INIT_LAST) ? S_FETCH : S_INIT;
      S_FETCH: next_state = S_EXEC;
      S_EXEC: begin
        if (bus.OPCODE == OPC_LOAD) begin
          next_state = S_WB;
        end else begin
          next_state = take_intr ? S_INTR : S_FETCH;
        end
      end
      S_WB:    next_state = take_intr ? S_INTR : S_FETCH;
      S_INTR:  next_state = S_FETCH;
      default: next_state = S_INIT;
    endcase
  end

  // Output decode from state, opcode and branch outcome.
  always_comb begin
    bus.PC_WRITE  = 1'b0;
    bus.PC_SOURCE = PCSEL_PLUS4;
    bus.RST       = 1'b0;
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_RDEN2 = 1'b0;
    bus.MEM_WE2   = 1'b0;
    bus.REG_WRITE = 1'b0;
    bus.CSR_WE    = 1'b0;
    bus.INT_TAKEN = 1'b0;
    bus.MRET_EXEC = 1'b0;
    case (state)
      S_INIT:  bus.RST = 1'b1;
      S_FETCH: bus.MEM_RDEN1 = 1'b1;
      S_EXEC: begin
        bus.PC_WRITE = 1'b1;
        case (bus.OPCODE)
          OPC_LOAD: begin
            bus.PC_WRITE  = 1'b0;
            bus.MEM_RDEN2 = 1'b1;
          end
          OPC_STORE:  bus.MEM_WE2 = 1'b1;
          OPC_BRANCH: bus.PC_SOURCE = bus.BR_TAKEN ? PCSEL_BRANCH : PCSEL_PLUS4;
          OPC_JAL: begin
            bus.PC_SOURCE = PCSEL_JAL;
            bus.REG_WRITE = 1'b1;
          end
          OPC_JALR: begin
            bus.PC_SOURCE = PCSEL_JALR;
            bus.REG_WRITE = 1'b1;
          end
          OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: bus.REG_WRITE = 1'b1;
          OPC_SYSTEM: begin
            if (bus.FUNC3 == 3'b000) begin
              bus.PC_SOURCE = PCSEL_MEPC;
              bus.MRET_EXEC = 1'b1;
            end else begin
              bus.CSR_WE    = 1'b1;
              bus.REG_WRITE = 1'b1;
            end
          end
          default: bus.PC_SOURCE = PCSEL_PLUS4;
        endcase
      end
      S_WB: begin
        bus.REG_WRITE = 1'b1;
        bus.PC_WRITE  = 1'b1;
      end
      S_INTR: begin
        bus.PC_WRITE  = 1'b1;
        bus.PC_SOURCE = PCSEL_MTVEC;
        bus.INT_TAKEN = 1'b1;
      end
      default: bus.RST = 1'b1;
    endcase
  end

endmodule
